unified_mem_arbiter: RTL and testbench

Shares one single-port, fixed-latency unified memory between the fetch stage (read-only) and the memory-access stage (read/write) of the pipelined CPU. Each port holds a request until a one-cycle ready pulse. The arbiter runs one access at a time through a latency-counting state machine. It drives the stall signals that freeze the corresponding pipeline stages while their access is pending.

---
 rtl/cpu_mem_pkg.sv | 15 +
 rtl/unified_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory path: arbiter state encoding and
// default bus widths used by the IF/MEM stages and the memory model.
package cpu_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_LAT    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the fetch port
// (read-only) and the data port (read/write). One access runs at a time; data
// wins ties because it belongs to the older instruction. Ready pulses arrive
// one cycle after the last busy cycle, and the stall outputs hold each
// pipeline stage while its request is outstanding.
module unified_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LAT    = DEF_LAT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_cancel,
    output logic              i_rdy,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rdy,
    output logic [DATA_W-1:0] d_rdata,

    output logic              stall_if,
    output logic              stall_mem,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned      CNT_W    = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              i_rdy_q, i_rdy_d;
    logic              d_rdy_q, d_rdy_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              i_req_eff;
    logic              d_req_eff;
    logic              accept_d;
    logic              accept_i;
    logic              last_cycle;
    logic              fetch_dropped;

    // A port's request is still the retiring one while its ready pulse is high.
    assign i_req_eff = i_req & ~i_rdy_q;
    assign d_req_eff = d_req & ~d_rdy_q;

    assign accept_d   = (state_q == IDLE) & d_req_eff;
    assign accept_i   = (state_q == IDLE) & ~d_req_eff & i_req_eff;
    assign last_cycle = (state_q != IDLE) & (cnt_q == CNT_ONE);

    // A cancel in the final busy cycle still counts, so fold in the live input.
    assign fetch_dropped = drop_q | i_cancel;

    // FSM next state, latency counter, flush flag and ready pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        i_rdy_d = 1'b0;
        d_rdy_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (accept_d) begin
                    state_d = BUSY_D;
                    cnt_d   = CNT_LOAD;
                end else if (accept_i) begin
                    state_d = BUSY_I;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY_I: begin
                cnt_d = cnt_q - CNT_ONE;
                if (i_cancel) begin
                    drop_d = 1'b1;
                end
                if (last_cycle) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    i_rdy_d = ~fetch_dropped;
                end
            end
            BUSY_D: begin
                cnt_d = cnt_q - CNT_ONE;
                if (last_cycle) begin
                    state_d = IDLE;
                    d_rdy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory command registers and read-data capture.
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        if (accept_d) begin
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
        end else if (accept_i) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = i_addr;
        end

        if (last_cycle) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            // A flushed fetch completes on the bus but leaves i_rdata alone.
            if (state_q == BUSY_I && !fetch_dropped) begin
                i_rdata_d = mem_rdata;
            end
            // Stores keep the last load value visible.
            if (state_q == BUSY_D && !mem_we_q) begin
                d_rdata_d = mem_rdata;
            end
        end
    end

    // State register; reset abandons any in-flight access without a ready pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdy_q     <= 1'b0;
            d_rdy_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdy_q     <= i_rdy_d;
            d_rdy_q     <= d_rdy_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign i_rdy   = i_rdy_q;
    assign d_rdy   = d_rdy_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    assign stall_if  = i_req & ~i_rdy_q;
    assign stall_mem = d_req & ~d_rdy_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a LAT=4 instance driven by a vector table and
// hand-written arbitration/cancel/reset sequences, plus a LAT=1 instance.
// Read data is checked by per-port scoreboards fed at request time.
module tb_unified_mem_arbiter;
    import cpu_mem_pkg::*;

    localparam int unsigned AW    = DEF_ADDR_W;
    localparam int unsigned DW    = DEF_DATA_W;
    localparam int unsigned LAT_A = 4;
    localparam int unsigned LAT_B = 1;
    localparam int          LA    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DUT A (LAT=4)
    logic          a_i_req = 0, a_i_cancel = 0, a_d_req = 0, a_d_we = 0;
    logic [AW-1:0] a_i_addr = '0, a_d_addr = '0;
    logic [DW-1:0] a_d_wdata = '0;
    logic          a_i_rdy, a_d_rdy, a_stall_if, a_stall_mem, a_mem_req, a_mem_we;
    logic [DW-1:0] a_i_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
    logic [AW-1:0] a_mem_addr;

    // DUT B (LAT=1)
    logic          b_i_req = 0, b_i_cancel = 0, b_d_req = 0, b_d_we = 0;
    logic [AW-1:0] b_i_addr = '0, b_d_addr = '0;
    logic [DW-1:0] b_d_wdata = '0;
    logic          b_i_rdy, b_d_rdy, b_stall_if, b_stall_mem, b_mem_req, b_mem_we;
    logic [DW-1:0] b_i_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
    logic [AW-1:0] b_mem_addr;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_cancel(a_i_cancel),
        .i_rdy(a_i_rdy), .i_rdata(a_i_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_rdy(a_d_rdy), .d_rdata(a_d_rdata),
        .stall_if(a_stall_if), .stall_mem(a_stall_mem),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_cancel(b_i_cancel),
        .i_rdy(b_i_rdy), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdy(b_d_rdy), .d_rdata(b_d_rdata),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Fixed-latency memory models: data is valid only in the LAT-th busy cycle.
    logic [DW-1:0] mem_a [4096];
    logic [DW-1:0] mem_b [4096];
    int mcnt_a = 0;
    int mcnt_b = 0;

    assign a_mem_rdata = (a_mem_req && mcnt_a == LA - 1) ? mem_a[a_mem_addr[11:0]] : 16'hDEAD;
    assign b_mem_rdata = (b_mem_req && mcnt_b == int'(LAT_B) - 1) ?
                         mem_b[b_mem_addr[11:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (a_mem_req) begin
            if (a_mem_we && mcnt_a == LA - 1) mem_a[a_mem_addr[11:0]] = a_mem_wdata;
            mcnt_a <= mcnt_a + 1;
        end else begin
            mcnt_a <= 0;
        end
        if (b_mem_req) begin
            if (b_mem_we && mcnt_b == int'(LAT_B) - 1) mem_b[b_mem_addr[11:0]] = b_mem_wdata;
            mcnt_b <= mcnt_b + 1;
        end else begin
            mcnt_b <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Scoreboards: expected read data per ready pulse.
    logic [DW-1:0] a_iq[$], a_dq[$], b_iq[$], b_dq[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (a_i_rdy) begin
                chk("a_i_rdy_expected", 32'(a_iq.size() != 0), 32'(1));
                if (a_iq.size() != 0) chk("a_i_rdata", 32'(a_i_rdata), 32'(a_iq.pop_front()));
            end
            if (a_d_rdy) begin
                chk("a_d_rdy_expected", 32'(a_dq.size() != 0), 32'(1));
                if (a_dq.size() != 0) chk("a_d_rdata", 32'(a_d_rdata), 32'(a_dq.pop_front()));
            end
            if (b_i_rdy) begin
                chk("b_i_rdy_expected", 32'(b_iq.size() != 0), 32'(1));
                if (b_iq.size() != 0) chk("b_i_rdata", 32'(b_i_rdata), 32'(b_iq.pop_front()));
            end
            if (b_d_rdy) begin
                chk("b_d_rdy_expected", 32'(b_dq.size() != 0), 32'(1));
                if (b_dq.size() != 0) chk("b_d_rdata", 32'(b_d_rdata), 32'(b_dq.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Advance a cycle; the requester drops a request once it has seen its ready.
    task automatic tick_drop_a();
        bit ir;
        bit dr;
        ir = a_i_rdy;
        dr = a_d_rdy;
        tick();
        if (ir) a_i_req = 1'b0;
        if (dr) a_d_req = 1'b0;
    endtask

    task automatic chk_a(input string tag, input int c, input bit mreq, input bit we,
                         input bit ir, input bit dr, input bit sif, input bit smem);
        logic [5:0] got_f;
        logic [5:0] want_f;
        got_f  = {a_mem_req, a_mem_we, a_i_rdy, a_d_rdy, a_stall_if, a_stall_mem};
        want_f = {mreq, we, ir, dr, sif, smem};
        chk($sformatf("%s c%0d flags{req,we,irdy,drdy,sif,smem}", tag, c),
            32'(got_f), 32'(want_f));
    endtask

    task automatic chk_b(input string tag, input int c, input bit mreq, input bit we,
                         input bit ir, input bit dr, input bit sif, input bit smem);
        logic [5:0] got_f;
        logic [5:0] want_f;
        got_f  = {b_mem_req, b_mem_we, b_i_rdy, b_d_rdy, b_stall_if, b_stall_mem};
        want_f = {mreq, we, ir, dr, sif, smem};
        chk($sformatf("%s c%0d flags{req,we,irdy,drdy,sif,smem}", tag, c),
            32'(got_f), 32'(want_f));
    endtask

    typedef struct {
        bit            is_d;
        bit            we;
        bit            preload;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] init;
        logic [DW-1:0] exp_rdata;  // rdata at the ready pulse (unchanged for stores)
        logic [DW-1:0] exp_word;   // memory word afterwards
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit busy;
        bit d_again;
        bit ir;
        bit dr;
        logic [DW-1:0] last_i;

        vecs[0] = '{0, 0, 1, 16'h0010, 16'h0000, 16'hA5A5, 16'hA5A5, 16'hA5A5};
        vecs[1] = '{1, 0, 1, 16'h0200, 16'h0000, 16'h5A5A, 16'h5A5A, 16'h5A5A};
        vecs[2] = '{1, 1, 1, 16'h0100, 16'h1234, 16'h0000, 16'h5A5A, 16'h1234};
        vecs[3] = '{0, 0, 1, 16'h0FFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'h1234, 16'h1234};
        vecs[5] = '{1, 1, 1, 16'h0ABC, 16'h0000, 16'hFFFF, 16'h1234, 16'h0000};

        // Reset state
        sample();
        chk_a("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset a_mem_addr", 32'(a_mem_addr), 32'(0));
        chk("reset a_i_rdata", 32'(a_i_rdata), 32'(0));
        chk("reset a_d_rdata", 32'(a_d_rdata), 32'(0));
        chk_b("reset_b", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();

        // Table: lone accesses on DUT A
        for (int k = 0; k < 6; k++) begin
            if (vecs[k].preload) mem_a[vecs[k].addr[11:0]] = vecs[k].init;
            for (int c = 0; c <= LA + 2; c++) begin
                if (c == 0) begin
                    if (vecs[k].is_d) begin
                        a_d_req   = 1'b1;
                        a_d_we    = vecs[k].we;
                        a_d_addr  = vecs[k].addr;
                        a_d_wdata = vecs[k].wdata;
                        a_dq.push_back(vecs[k].exp_rdata);
                    end else begin
                        a_i_req  = 1'b1;
                        a_i_addr = vecs[k].addr;
                        a_iq.push_back(vecs[k].exp_rdata);
                    end
                end
                sample();
                busy = (c >= 1 && c <= LA);
                chk_a($sformatf("vec%0d", k), c, busy, busy & vecs[k].is_d & vecs[k].we,
                      !vecs[k].is_d && c == LA + 1, vecs[k].is_d && c == LA + 1,
                      !vecs[k].is_d && c <= LA, vecs[k].is_d && c <= LA);
                if (busy) begin
                    chk($sformatf("vec%0d c%0d mem_addr", k, c), 32'(a_mem_addr),
                        32'(vecs[k].addr));
                    if (vecs[k].is_d && vecs[k].we)
                        chk($sformatf("vec%0d c%0d mem_wdata", k, c), 32'(a_mem_wdata),
                            32'(vecs[k].wdata));
                end
                tick_drop_a();
            end
            chk($sformatf("vec%0d mem word", k), 32'(mem_a[vecs[k].addr[11:0]]),
                32'(vecs[k].exp_word));
        end

        // Both ports at once: data first, fetch accepted in the data ready cycle
        a_d_req  = 1'b1;
        a_d_we   = 1'b0;
        a_d_addr = 16'h0200;
        a_i_req  = 1'b1;
        a_i_addr = 16'h0010;
        a_dq.push_back(16'h5A5A);
        a_iq.push_back(16'hA5A5);
        for (int c = 0; c <= 2 * LA + 3; c++) begin
            sample();
            chk_a("both", c, (c >= 1 && c <= LA) || (c >= LA + 2 && c <= 2 * LA + 1), 0,
                  c == 2 * LA + 2, c == LA + 1, c <= 2 * LA + 1, c <= LA);
            if (c == 2) chk("both c2 mem_addr", 32'(a_mem_addr), 32'(16'h0200));
            if (c == 7) chk("both c7 mem_addr", 32'(a_mem_addr), 32'(16'h0010));
            tick_drop_a();
        end
        last_i = 16'hA5A5;

        // Fetch cancelled in cycle 2; next fetch accepted in the would-be ready cycle
        mem_a[12'h020] = 16'h7777;
        mem_a[12'h040] = 16'h4242;
        a_i_req  = 1'b1;
        a_i_addr = 16'h0020;
        for (int c = 0; c <= 2 * LA + 3; c++) begin
            if (c == 2) a_i_cancel = 1'b1;
            if (c == 3) begin
                a_i_cancel = 1'b0;
                a_i_addr   = 16'h0040;
                a_iq.push_back(16'h4242);
            end
            sample();
            chk_a("cancel", c, (c >= 1 && c <= LA) || (c >= LA + 2 && c <= 2 * LA + 1), 0,
                  c == 2 * LA + 2, 0, c <= 2 * LA + 1, 0);
            if (c == 2) chk("cancel c2 mem_addr", 32'(a_mem_addr), 32'(16'h0020));
            if (c == LA + 1) chk("cancel i_rdata kept", 32'(a_i_rdata), 32'(last_i));
            if (c == 7) chk("cancel c7 mem_addr", 32'(a_mem_addr), 32'(16'h0040));
            tick_drop_a();
        end

        // Asynchronous reset in cycle 3 of a data read, then re-presented
        mem_a[12'h300] = 16'h3333;
        a_d_req  = 1'b1;
        a_d_we   = 1'b0;
        a_d_addr = 16'h0300;
        a_dq.push_back(16'h3333);
        for (int c = 0; c <= 10; c++) begin
            if (c == 3) begin
                #2;
                rst = 1'b1;
                #1;
                chk("rst flags{req,we,irdy,drdy}",
                    32'({a_mem_req, a_mem_we, a_i_rdy, a_d_rdy}), 32'(0));
                chk("rst mem_addr", 32'(a_mem_addr), 32'(0));
                chk("rst i_rdata", 32'(a_i_rdata), 32'(0));
                chk("rst d_rdata", 32'(a_d_rdata), 32'(0));
                a_dq.delete();
            end
            if (c == 4) begin
                rst = 1'b0;
                a_dq.push_back(16'h3333);
            end
            sample();
            chk_a("reset_mid", c, (c >= 1 && c <= 2) || (c >= 5 && c <= 8), 0,
                  0, c == 9, 0, c <= 8);
            if (c == 6) chk("reset_mid c6 mem_addr", 32'(a_mem_addr), 32'(16'h0300));
            tick_drop_a();
        end

        // DUT B, LAT=1: lone fetch
        mem_b[12'h001] = 16'h1111;
        b_i_req  = 1'b1;
        b_i_addr = 16'h0001;
        b_iq.push_back(16'h1111);
        for (int c = 0; c <= 3; c++) begin
            sample();
            chk_b("lat1_fetch", c, c == 1, 0, c == 2, 0, c <= 1, 0);
            ir = b_i_rdy;
            tick();
            if (ir) b_i_req = 1'b0;
        end

        // DUT B: both ports continuously pending, one completion every 2 cycles
        mem_b[12'h002] = 16'h2222;
        mem_b[12'h100] = 16'hBEEF;
        mem_b[12'h101] = 16'hCAFE;
        b_d_req  = 1'b1;
        b_d_we   = 1'b0;
        b_d_addr = 16'h0100;
        b_i_req  = 1'b1;
        b_i_addr = 16'h0002;
        b_dq.push_back(16'hBEEF);
        b_iq.push_back(16'h2222);
        d_again = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            sample();
            chk_b("lat1_alt", c, c == 1 || c == 3 || c == 5, 0, c == 4, c == 2 || c == 6,
                  c <= 3, c <= 1 || (c >= 3 && c <= 5));
            if (c == 1) chk("lat1_alt c1 mem_addr", 32'(b_mem_addr), 32'(16'h0100));
            if (c == 3) chk("lat1_alt c3 mem_addr", 32'(b_mem_addr), 32'(16'h0002));
            if (c == 5) chk("lat1_alt c5 mem_addr", 32'(b_mem_addr), 32'(16'h0101));
            ir = b_i_rdy;
            dr = b_d_rdy;
            tick();
            if (ir) b_i_req = 1'b0;
            if (dr) begin
                if (!d_again) begin
                    d_again  = 1'b1;
                    b_d_addr = 16'h0101;
                    b_dq.push_back(16'hCAFE);
                end else begin
                    b_d_req = 1'b0;
                end
            end
        end

        chk("a_iq drained", 32'(a_iq.size()), 32'(0));
        chk("a_dq drained", 32'(a_dq.size()), 32'(0));
        chk("b_iq drained", 32'(b_iq.size()), 32'(0));
        chk("b_dq drained", 32'(b_dq.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
